// File: rtl/line_addr_composer.sv
// line_addr_composer
// Rebuilds full byte addresses from a cache line's tag/index fields and
// issues them as a 16-beat word burst, starting at the requested block
// offset and wrapping inside the line (critical-word-first).
// The word offset bits are always zero; the offset adder is OFFSET_W bits
// wide, so it can never carry into the index or tag.
module line_addr_composer #(
  parameter int TAG_W    = 19,
  parameter int INDEX_W  = 7,
  parameter int OFFSET_W = 4,
  parameter int WORD_W   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [TAG_W-1:0]    tag,
  input  logic [INDEX_W-1:0]  index,
  input  logic [OFFSET_W-1:0] start_offset,
  input  logic                abort,
  input  logic                mem_ready,
  output logic                mem_valid,
  output logic [31:0]         mem_addr,
  output logic                mem_last,
  output logic [OFFSET_W-1:0] beat_cnt,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [TAG_W-1:0]    tag_r;
  logic [INDEX_W-1:0]  index_r;
  logic [OFFSET_W-1:0] off_r;
  logic [OFFSET_W-1:0] cnt_r;
  logic [OFFSET_W-1:0] cur_off_s;
  logic                accept_s;
  logic                final_beat_s;

  // Beat bookkeeping shared by next-state and datapath logic.
  always_comb begin
    cur_off_s    = off_r + cnt_r;
    accept_s     = (state_r == ISSUE) && mem_ready;
    final_beat_s = (cnt_r == {OFFSET_W{1'b1}});
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decision: abort wins over a final-beat handshake.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (abort) begin
          state_s = IDLE;
        end else if (accept_s && final_beat_s) begin
          state_s = DONE;
        end else begin
          state_s = ISSUE;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Latched line fields and beat counter; start is only honoured in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_r   <= {TAG_W{1'b0}};
      index_r <= {INDEX_W{1'b0}};
      off_r   <= {OFFSET_W{1'b0}};
      cnt_r   <= {OFFSET_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            tag_r   <= tag;
            index_r <= index;
            off_r   <= start_offset;
            cnt_r   <= {OFFSET_W{1'b0}};
          end
        end
        ISSUE: begin
          // Abort clears the count so beat_cnt reads zero once idle.
          // A full burst wraps the count back to zero on its own.
          if (abort) begin
            cnt_r <= {OFFSET_W{1'b0}};
          end else if (accept_s) begin
            cnt_r <= cnt_r + OFFSET_W'(1);
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Outputs decoded only from registered state, never from start.
  always_comb begin
    mem_valid = 1'b0;
    mem_addr  = 32'd0;
    mem_last  = 1'b0;
    beat_cnt  = {OFFSET_W{1'b0}};
    busy      = 1'b0;
    done      = 1'b0;
    case (state_r)
      ISSUE: begin
        mem_valid = 1'b1;
        mem_addr  = {tag_r, index_r, cur_off_s, {WORD_W{1'b0}}};
        mem_last  = final_beat_s;
        beat_cnt  = cnt_r;
        busy      = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        mem_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_line_addr_composer.sv
// Directed testbench for line_addr_composer.
module tb_line_addr_composer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [18:0] tag;
  logic [6:0]  index;
  logic [3:0]  start_offset;
  logic        abort;
  logic        mem_ready;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic        mem_last;
  logic [3:0]  beat_cnt;
  logic        busy;
  logic        done;

  int vectors;
  int miscompares;
  int issue_cycles;

  localparam logic [31:0] BASE_A = 32'h2468_AA80; // tag 0x12345, index 0x2A
  localparam logic [31:0] BASE_B = 32'hFFFF_E040; // tag 0x7FFFF, index 0x01

  line_addr_composer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .tag          (tag),
    .index        (index),
    .start_offset (start_offset),
    .abort        (abort),
    .mem_ready    (mem_ready),
    .mem_valid    (mem_valid),
    .mem_addr     (mem_addr),
    .mem_last     (mem_last),
    .beat_cnt     (beat_cnt),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string name, input logic v, input logic l,
                         input logic [3:0] b, input logic bz, input logic d);
    chk({name, ".valid"}, 32'(mem_valid), 32'(v));
    chk({name, ".last"},  32'(mem_last),  32'(l));
    chk({name, ".beat"},  32'(beat_cnt),  32'(b));
    chk({name, ".busy"},  32'(busy),      32'(bz));
    chk({name, ".done"},  32'(done),      32'(d));
  endtask

  // Hand-written line arithmetic: word (off+i) mod 16 within the line.
  function automatic logic [31:0] exp_addr(input logic [31:0] base, input int off, input int i);
    return base + 32'(((off + i) % 16) * 4);
  endfunction

  task automatic chk_beat(input string name, input logic [31:0] base, input int off, input int i);
    chk_ctl($sformatf("%s[%0d]", name, i), 1'b1, (i == 15), 4'(i), 1'b1, 1'b0);
    chk($sformatf("%s[%0d].addr", name, i), mem_addr, exp_addr(base, off, i));
  endtask

  task automatic launch(input logic [18:0] t, input logic [6:0] x, input logic [3:0] o);
    tag          = t;
    index        = x;
    start_offset = o;
    start        = 1'b1;
    step();
    start        = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    start        = 1'b0;
    tag          = 19'd0;
    index        = 7'd0;
    start_offset = 4'd0;
    abort        = 1'b0;
    mem_ready    = 1'b0;

    // Reset state before any clock edge.
    #2;
    chk_ctl("reset", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("reset.addr", mem_addr, 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    chk_ctl("idle", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    // Linear burst, offset 0, ready held high.
    mem_ready = 1'b1;
    launch(19'h12345, 7'h2A, 4'd0);
    chk("lin.first", mem_addr, 32'h2468_AA80);
    for (int i = 0; i < 16; i++) begin
      chk_beat("lin", BASE_A, 0, i);
      if (i == 15) chk("lin.lastaddr", mem_addr, 32'h2468_AABC);
      step();
    end
    chk_ctl("lin.done", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    step();
    chk_ctl("lin.idle", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    // Wrap burst starting at word 13.
    launch(19'h12345, 7'h2A, 4'd13);
    chk("wrap.first", mem_addr, 32'h2468_AAB4);
    for (int i = 0; i < 16; i++) begin
      chk_beat("wrap", BASE_A, 13, i);
      if (i == 3)  chk("wrap.wrapped", mem_addr, 32'h2468_AA80);
      if (i == 15) chk("wrap.lastaddr", mem_addr, 32'h2468_AAB0);
      step();
    end
    chk_ctl("wrap.done", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    step();
    chk_ctl("wrap.idle", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    // Backpressure: ready low for 3 cycles at beat 5.
    launch(19'h12345, 7'h2A, 4'd0);
    issue_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      chk_beat("bp", BASE_A, 0, i);
      issue_cycles += mem_valid ? 1 : 0;
      step();
    end
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_beat($sformatf("bp.hold%0d", k), BASE_A, 0, 5);
      chk("bp.holdaddr", mem_addr, 32'h2468_AA94);
      issue_cycles += mem_valid ? 1 : 0;
      step();
    end
    mem_ready = 1'b1;
    for (int i = 5; i < 16; i++) begin
      chk_beat("bp", BASE_A, 0, i);
      issue_cycles += mem_valid ? 1 : 0;
      step();
    end
    chk("bp.cycles", 32'(issue_cycles), 32'd19);
    chk_ctl("bp.done", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    step();
    chk_ctl("bp.idle", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    // Start pulses while busy are ignored (at beat 8 and in DONE).
    launch(19'h12345, 7'h2A, 4'd0);
    for (int i = 0; i < 16; i++) begin
      chk_beat("ign", BASE_A, 0, i);
      if (i == 8) begin
        tag          = 19'h7FFFF;
        index        = 7'h01;
        start_offset = 4'd3;
        start        = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    chk_ctl("ign.done", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_ctl("ign.idle", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    step();
    chk_ctl("ign.idle2", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    // Abort at beat 7 with ready low; then a fresh burst.
    launch(19'h7FFFF, 7'h01, 4'd3);
    chk("ab.first", mem_addr, 32'hFFFF_E04C);
    for (int i = 0; i < 7; i++) begin
      chk_beat("ab", BASE_B, 3, i);
      step();
    end
    chk_beat("ab", BASE_B, 3, 7);
    mem_ready = 1'b0;
    abort     = 1'b1;
    step();
    abort = 1'b0;
    chk_ctl("ab.after", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ab.nodone", 32'(done), 32'd0);
    end
    mem_ready = 1'b1;
    launch(19'h12345, 7'h2A, 4'd9);
    chk("fresh.first", mem_addr, 32'h2468_AAA4);
    for (int i = 0; i < 10; i++) begin
      chk_beat("fresh", BASE_A, 9, i);
      step();
    end

    // Async reset between edges at beat 10.
    chk_beat("rst", BASE_A, 9, 10);
    #2;
    rst = 1'b1;
    #1;
    chk_ctl("arst", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("arst.addr", mem_addr, 32'd0);
    #2;
    rst = 1'b0;
    step();
    chk_ctl("arst.idle", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    launch(19'h12345, 7'h2A, 4'd15);
    chk("post.first", mem_addr, 32'h2468_AABC);
    chk_beat("post", BASE_A, 15, 0);
    step();
    chk("post.wrap", mem_addr, 32'h2468_AA80);
    chk_beat("post", BASE_A, 15, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
